// File: rtl/fifo_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module : fifo_arb_pkg
// Brief  : Shared types and round-robin index helpers for fifo_read_arbiter.
// Rev    : 1.0  initial release
// ============================================================================
package fifo_arb_pkg;

  typedef enum logic [0:0] {
    S_ARB  = 1'b0,
    S_HOLD = 1'b1
  } arb_state_e;

  // Modular add for indices already below n, with off < n.
  function automatic int unsigned rr_add(input int unsigned ptr, input int unsigned off,
                                         input int unsigned n);
    int unsigned s;
    s = ptr + off;
    return (s >= n) ? (s - n) : s;
  endfunction

  function automatic int unsigned rr_next(input int unsigned ptr, input int unsigned n);
    return rr_add(ptr, 1, n);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fifo_read_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module : fifo_read_arbiter_if
// Brief  : FIFO read port plus consumer request/grant/data bundle.
// Rev    : 1.0  initial release
// ============================================================================
interface fifo_read_arbiter_if #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8
);
  logic [NUM_REQ-1:0]    req;
  logic                  read_empty;
  logic [DATA_WIDTH-1:0] read_data;
  logic                  read_enable;
  logic [NUM_REQ-1:0]    grant;
  logic [DATA_WIDTH-1:0] data_out;
  logic [NUM_REQ-1:0]    data_valid;

  // master: the arbiter, which owns the FIFO pop and the consumer results
  modport master (
    input  req, read_empty, read_data,
    output read_enable, grant, data_out, data_valid
  );

  modport slave (
    output req, read_empty, read_data,
    input  read_enable, grant, data_out, data_valid
  );
endinterface
`default_nettype wire

// File: rtl/fifo_read_arbiter_pick.sv
`default_nettype none
// ============================================================================
// Module : rr_priority_pick
// Brief  : Combinational rotate-search: first set req bit starting at ptr.
// Rev    : 1.0  initial release
// ============================================================================
module rr_priority_pick
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ = 4,
  parameter int IDX_W   = 2
) (
  input  wire logic [NUM_REQ-1:0] req,
  input  wire logic [IDX_W-1:0]   ptr,
  output logic      [NUM_REQ-1:0] win_oh,
  output logic      [IDX_W-1:0]   win_idx,
  output logic                    win_any
);

  logic [IDX_W-1:0] cand;

  always_comb begin
    win_oh  = '0;
    win_idx = '0;
    win_any = 1'b0;
    cand    = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = IDX_W'(rr_add(32'(ptr), i, NUM_REQ));
      if (!win_any && req[cand]) begin
        win_any      = 1'b1;
        win_oh[cand] = 1'b1;
        win_idx      = cand;
      end
    end
  end

endmodule
`default_nettype wire

// File: rtl/fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : fifo_read_arbiter
// Brief  : Round-robin share of one FIFO read port; optional burst ownership
//          enabled by defining FIFO_RD_ARB_BURST_EN.
// Rev    : 1.0  initial release
// ============================================================================
module fifo_read_arbiter
  import fifo_arb_pkg::*;
#(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 8,
  parameter int BURST_LEN  = 4
) (
  input wire logic            read_clock,
  input wire logic            reset,
  fifo_read_arbiter_if.master bus
);

  localparam int IDX_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]    eligible;
  logic [NUM_REQ-1:0]    win_oh;
  logic [IDX_W-1:0]      win_idx;
  logic                  win_any;
  logic                  pop;
  logic [NUM_REQ-1:0]    grant;
  logic [IDX_W-1:0]      ptr_q, ptr_d;
  logic [DATA_WIDTH-1:0] data_out_q, data_out_d;
  logic [NUM_REQ-1:0]    data_valid_q, data_valid_d;

  rr_priority_pick #(
    .NUM_REQ (NUM_REQ),
    .IDX_W   (IDX_W)
  ) u_pick (
    .req     (eligible),
    .ptr     (ptr_q),
    .win_oh  (win_oh),
    .win_idx (win_idx),
    .win_any (win_any)
  );

  assign pop             = win_any & ~bus.read_empty & ~reset;
  assign grant           = pop ? win_oh : '0;
  assign bus.read_enable = pop;
  assign bus.grant       = grant;

  // read_data carries the head word, so it is captured on the pop edge itself
  assign data_out_d   = pop ? bus.read_data : data_out_q;
  assign data_valid_d = grant;

`ifdef FIFO_RD_ARB_BURST_EN
  localparam int CNT_W = $clog2(BURST_LEN + 1);

  arb_state_e         state_q, state_d;
  logic [IDX_W-1:0]   owner_q, owner_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [NUM_REQ-1:0] owner_oh;
  logic               hold_exit;

  always_comb begin
    owner_oh          = '0;
    owner_oh[owner_q] = 1'b1;
    hold_exit = (cnt_q == CNT_W'(BURST_LEN)) | ~bus.req[owner_q] | bus.read_empty;
    if (state_q == S_HOLD) begin
      eligible = hold_exit ? '0 : (bus.req & owner_oh);
    end else begin
      eligible = bus.req;
    end
  end

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    cnt_d   = cnt_q;
    ptr_d   = ptr_q;
    case (state_q)
      S_ARB: begin
        if (pop) begin
          state_d = S_HOLD;
          owner_d = win_idx;
          cnt_d   = CNT_W'(1);
          ptr_d   = IDX_W'(rr_next(32'(win_idx), NUM_REQ));
        end
      end
      S_HOLD: begin
        // The exit cycle never pops; arbitration resumes on the next cycle.
        if (hold_exit) begin
          state_d = S_ARB;
          cnt_d   = '0;
          ptr_d   = IDX_W'(rr_next(32'(owner_q), NUM_REQ));
        end else if (pop) begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = S_ARB;
    endcase
  end

  always_ff @(posedge read_clock or posedge reset) begin
    if (reset) begin
      state_q <= S_ARB;
      owner_q <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      cnt_q   <= cnt_d;
    end
  end
`else
  assign eligible = bus.req;
  assign ptr_d    = pop ? IDX_W'(rr_next(32'(win_idx), NUM_REQ)) : ptr_q;
`endif

  always_ff @(posedge read_clock or posedge reset) begin
    if (reset) begin
      ptr_q        <= '0;
      data_out_q   <= '0;
      data_valid_q <= '0;
    end else begin
      ptr_q        <= ptr_d;
      data_out_q   <= data_out_d;
      data_valid_q <= data_valid_d;
    end
  end

  assign bus.data_out   = data_out_q;
  assign bus.data_valid = data_valid_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_read_arbiter.sv
`default_nettype none
// ============================================================================
// Module : tb_fifo_read_arbiter
// Brief  : Directed self-checking bench for fifo_read_arbiter with a FIFO model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_fifo_read_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_read_arbiter_if #(.NUM_REQ(4), .DATA_WIDTH(8)) bus ();

  fifo_read_arbiter #(
    .NUM_REQ    (4),
    .DATA_WIDTH (8),
    .BURST_LEN  (4)
  ) dut (
    .read_clock (clk),
    .reset      (rst),
    .bus        (bus)
  );

  // FIFO model: head word on read_data, empty flag registered on the clock
  logic [7:0]  mem [0:63];
  logic [31:0] wr_ptr  = '0;
  logic [31:0] rd_ptr  = '0;
  logic        empty_q = 1'b1;
  int          n_cmp   = 0;
  int          n_err   = 0;

  always @(posedge clk) begin
    rd_ptr  <= rd_ptr + (bus.read_enable ? 32'd1 : 32'd0);
    empty_q <= ((rd_ptr + (bus.read_enable ? 32'd1 : 32'd0)) == wr_ptr);
  end

  assign bus.read_data  = mem[rd_ptr[5:0]];
  assign bus.read_empty = empty_q;

  task automatic push(input logic [7:0] w);
    mem[wr_ptr[5:0]] = w;
    wr_ptr = wr_ptr + 32'd1;
  endtask

  task automatic flush();
    wr_ptr = rd_ptr;
  endtask

  task automatic test_reset();
    bus.req = '0;
    #1 rst = 1'b1;
    @(negedge clk); push(8'h55);
    @(negedge clk); bus.req = 4'b1111; #1;
    n_cmp++; if (bus.read_enable !== 1'b0) begin n_err++; $display("FAIL rst_ren: got %b want 0", bus.read_enable); end
    n_cmp++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL rst_grant: got %b want 0000", bus.grant); end
    n_cmp++; if (bus.data_valid !== 4'b0000) begin n_err++; $display("FAIL rst_dv: got %b want 0000", bus.data_valid); end
    n_cmp++; if (bus.data_out !== 8'h00) begin n_err++; $display("FAIL rst_dout: got %h want 00", bus.data_out); end
    bus.req = '0;
    flush();
    @(negedge clk); @(negedge clk);
    rst = 1'b0; #1;
    n_cmp++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL rst_idle_grant: got %b want 0000", bus.grant); end
  endtask

  task automatic test_round_robin();
    logic [3:0] eg;
    logic [3:0] ed;
    for (int i = 0; i < 8; i++) push(8'(8'hA0 + i));
    @(negedge clk);
    bus.req = 4'b1111;
    for (int k = 0; k <= 8; k++) begin
      #1;
      eg = (k < 8) ? 4'(1 << (k % 4)) : 4'b0000;
      ed = (k >= 1) ? 4'(1 << ((k - 1) % 4)) : 4'b0000;
      n_cmp++; if (bus.grant !== eg) begin n_err++; $display("FAIL rr_grant[%0d]: got %b want %b", k, bus.grant, eg); end
      n_cmp++; if (bus.read_enable !== (k < 8)) begin n_err++; $display("FAIL rr_ren[%0d]: got %b want %b", k, bus.read_enable, (k < 8)); end
      n_cmp++; if (bus.data_valid !== ed) begin n_err++; $display("FAIL rr_dv[%0d]: got %b want %b", k, bus.data_valid, ed); end
      if (k >= 1) begin
        n_cmp++; if (bus.data_out !== 8'(8'hA0 + k - 1)) begin n_err++; $display("FAIL rr_dout[%0d]: got %h want %h", k, bus.data_out, 8'(8'hA0 + k - 1)); end
      end
      @(negedge clk);
    end
    bus.req = '0; #1;
    n_cmp++; if (bus.data_valid !== 4'b0000) begin n_err++; $display("FAIL rr_dv_end: got %b want 0000", bus.data_valid); end
  endtask

  task automatic test_empty();
    push(8'hB0); push(8'hB1);
    @(negedge clk); bus.req = 4'b0101; #1;
    n_cmp++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL emp_g0: got %b want 0001", bus.grant); end
    @(negedge clk); #1;
    n_cmp++; if (bus.grant !== 4'b0100) begin n_err++; $display("FAIL emp_g2: got %b want 0100", bus.grant); end
    n_cmp++; if (bus.data_valid !== 4'b0001 || bus.data_out !== 8'hB0) begin n_err++; $display("FAIL emp_d0: got %b/%h want 0001/b0", bus.data_valid, bus.data_out); end
    @(negedge clk); #1;
    n_cmp++; if (bus.read_enable !== 1'b0 || bus.grant !== 4'b0000) begin n_err++; $display("FAIL emp_hold: got %b/%b want 0/0000", bus.read_enable, bus.grant); end
    n_cmp++; if (bus.data_valid !== 4'b0100 || bus.data_out !== 8'hB1) begin n_err++; $display("FAIL emp_d2: got %b/%h want 0100/b1", bus.data_valid, bus.data_out); end
    @(negedge clk); #1;
    n_cmp++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL emp_idle: got %b want 0000", bus.grant); end
    push(8'hC0);
    @(negedge clk); #1;
    n_cmp++; if (bus.grant !== 4'b0001) begin n_err++; $display("FAIL emp_refill: got %b want 0001", bus.grant); end
    @(negedge clk); #1;
    n_cmp++; if (bus.data_valid !== 4'b0001 || bus.data_out !== 8'hC0) begin n_err++; $display("FAIL emp_dc: got %b/%h want 0001/c0", bus.data_valid, bus.data_out); end
    bus.req = '0;
  endtask

  task automatic test_req_drop();
    push(8'hD0); push(8'hD1);
    @(negedge clk); bus.req = 4'b0010; #1;
    n_cmp++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL drop_grant: got %b want 0010", bus.grant); end
    @(negedge clk); bus.req = 4'b0000; #1;
    n_cmp++; if (bus.data_valid !== 4'b0010 || bus.data_out !== 8'hD0) begin n_err++; $display("FAIL drop_data: got %b/%h want 0010/d0", bus.data_valid, bus.data_out); end
    n_cmp++; if (bus.grant !== 4'b0000) begin n_err++; $display("FAIL drop_nogrant: got %b want 0000", bus.grant); end
    flush();
    @(negedge clk);
  endtask

  task automatic test_burst();
    logic [3:0] eg [13] = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
                            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
                            4'b0001, 4'b0001, 4'b0000};
    int w;
    w = 0;
    for (int i = 0; i < 10; i++) push(8'(8'hF0 + i));
    @(negedge clk); bus.req = 4'b0011;
    for (int k = 0; k <= 13; k++) begin
      #1;
      if (k < 13) begin
        n_cmp++; if (bus.grant !== eg[k]) begin n_err++; $display("FAIL burst_grant[%0d]: got %b want %b", k, bus.grant, eg[k]); end
      end
      if (k >= 1) begin
        n_cmp++; if (bus.data_valid !== eg[k-1]) begin n_err++; $display("FAIL burst_dv[%0d]: got %b want %b", k, bus.data_valid, eg[k-1]); end
        if (eg[k-1] != 4'b0000) begin
          n_cmp++; if (bus.data_out !== 8'(8'hF0 + w)) begin n_err++; $display("FAIL burst_dout[%0d]: got %h want %h", k, bus.data_out, 8'(8'hF0 + w)); end
          w++;
        end
      end
      @(negedge clk);
    end
    bus.req = '0;
  endtask

  task automatic test_reset_midstream(input logic [3:0] exp_first);
    push(8'hE0); push(8'hE1); push(8'hE2);
    @(negedge clk); bus.req = 4'b1010; #1;
    n_cmp++; if (bus.grant !== exp_first || bus.read_enable !== 1'b1) begin n_err++; $display("FAIL mid_grant: got %b/%b want %b/1", bus.grant, bus.read_enable, exp_first); end
    rst = 1'b1; #1;
    n_cmp++; if (bus.read_enable !== 1'b0 || bus.grant !== 4'b0000) begin n_err++; $display("FAIL mid_rst_ren: got %b/%b want 0/0000", bus.read_enable, bus.grant); end
    @(negedge clk); #1;
    n_cmp++; if (bus.data_valid !== 4'b0000) begin n_err++; $display("FAIL mid_rst_dv: got %b want 0000", bus.data_valid); end
    rst = 1'b0; #1;
    n_cmp++; if (bus.grant !== 4'b0010) begin n_err++; $display("FAIL mid_first: got %b want 0010", bus.grant); end
    @(negedge clk); #1;
    n_cmp++; if (bus.data_valid !== 4'b0010 || bus.data_out !== 8'hE0) begin n_err++; $display("FAIL mid_data: got %b/%h want 0010/e0", bus.data_valid, bus.data_out); end
    bus.req = '0;
  endtask

  initial begin
    test_reset();
`ifdef FIFO_RD_ARB_BURST_EN
    test_burst();
    test_reset_midstream(4'b0010);
`else
    test_round_robin();
    test_empty();
    test_req_drop();
    test_reset_midstream(4'b1000);
`endif
    @(negedge clk);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
`default_nettype wire
